// File: rtl/receiver_pkg.sv
// rtl/receiver_pkg.sv - shared defaults and helpers for the receiver channel aggregator
package receiver_pkg;

    localparam int DEFAULT_DATA_WIDTH = 17;
    localparam int DEFAULT_TS_WIDTH   = 24;
    // 10 ms of clk_96MHz ticks
    localparam int DEFAULT_MAX_AGE    = 960000;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int chan_idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin priority search starting after the last grant
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_valid_o
);

    // Walk candidates from farthest to nearest so the one right after ptr_i wins.
    always_comb begin
        int j;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        j           = 0;
        for (int k = N; k >= 1; k--) begin
            j = int'(ptr_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (req_i[j]) begin
                gnt_idx_o   = IDX_W'(j);
                gnt_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/receiver_channel_aggregator.sv
// rtl/receiver_channel_aggregator.sv - per-channel capture slots merged onto one valid/ready stream
module receiver_channel_aggregator
    import receiver_pkg::*;
#(
    parameter int N_CHANNELS = 4,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int TS_WIDTH   = DEFAULT_TS_WIDTH,
    parameter int MAX_AGE    = DEFAULT_MAX_AGE,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                                     clk_96MHz,
    input  logic                                     reset,
    input  logic [N_CHANNELS-1:0]                    data_availible,
    input  logic [N_CHANNELS*DATA_WIDTH-1:0]         decoded_data,
    input  logic [N_CHANNELS*TS_WIDTH-1:0]           timestamp_last_data,
    input  logic [TS_WIDTH-1:0]                      system_timestamp,
    output logic [N_CHANNELS-1:0]                    reset_bmc_decoder,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [chan_idx_width(N_CHANNELS)-1:0]    out_channel,
    output logic [DATA_WIDTH-1:0]                    out_data,
    output logic [TS_WIDTH-1:0]                      out_timestamp,
    output logic [N_CHANNELS*CNT_WIDTH-1:0]          drop_count,
    output logic                                     any_pending
);

    localparam int CH_W = chan_idx_width(N_CHANNELS);
    localparam logic [63:0] MAX_AGE_W = 64'(MAX_AGE);

    logic [N_CHANNELS-1:0] avail_q;
    logic [N_CHANNELS-1:0] rbmc_q;
    logic                  armed_q;
    logic [N_CHANNELS-1:0] rise;

    logic [N_CHANNELS-1:0] slot_full;
    logic [DATA_WIDTH-1:0] slot_data [N_CHANNELS];
    logic [TS_WIDTH-1:0]   slot_ts   [N_CHANNELS];

    logic                  out_valid_q;
    logic [CH_W-1:0]       out_channel_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [TS_WIDTH-1:0]   out_ts_q;
    logic [CH_W-1:0]       ptr_q;

    logic [CH_W-1:0]       gnt_idx;
    logic                  gnt_valid;
    logic                  load_out;

    // Edges are masked for the first cycle after reset so a level that was
    // already high while in reset is not mistaken for a fresh word.
    assign rise     = data_availible & ~avail_q & {N_CHANNELS{armed_q}};
    assign load_out = !out_valid_q || out_ready;

    // Edge-detect history and the one-cycle decoder re-arm pulse.
    always_ff @(posedge clk_96MHz or posedge reset) begin
        if (reset) begin
            avail_q <= '0;
            rbmc_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            avail_q <= data_availible;
            rbmc_q  <= rise;
            armed_q <= 1'b1;
        end
    end

    rr_arbiter #(
        .N     (N_CHANNELS),
        .IDX_W (CH_W)
    ) u_rr_arbiter (
        .req_i       (slot_full),
        .ptr_i       (ptr_q),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    // Output register: refills whenever empty or being consumed this cycle.
    always_ff @(posedge clk_96MHz or posedge reset) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            out_channel_q <= '0;
            out_data_q    <= '0;
            out_ts_q      <= '0;
            ptr_q         <= CH_W'(N_CHANNELS - 1);
        end else if (load_out) begin
            out_valid_q <= gnt_valid;
            if (gnt_valid) begin
                out_channel_q <= gnt_idx;
                out_data_q    <= slot_data[gnt_idx];
                out_ts_q      <= slot_ts[gnt_idx];
                ptr_q         <= gnt_idx;
            end
        end
    end

    for (genvar i = 0; i < N_CHANNELS; i++) begin : g_slot
        logic                  full_q, full_d;
        logic [DATA_WIDTH-1:0] data_q, data_d;
        logic [TS_WIDTH-1:0]   ts_q, ts_d;
        logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
        logic [TS_WIDTH-1:0]   age;
        logic                  granted;
        logic                  aged;
        logic                  drop;

        assign granted = load_out && gnt_valid && (gnt_idx == CH_W'(i));
        assign age     = system_timestamp - ts_q;
        assign aged    = (MAX_AGE > 0) && full_q && (64'(age) > MAX_AGE_W);

        // Capture beats grant beats ageing; a drop is only a word nobody will see.
        always_comb begin
            full_d = full_q;
            data_d = data_q;
            ts_d   = ts_q;
            drop   = 1'b0;
            if (rise[i]) begin
                full_d = 1'b1;
                data_d = decoded_data[i*DATA_WIDTH +: DATA_WIDTH];
                ts_d   = timestamp_last_data[i*TS_WIDTH +: TS_WIDTH];
                drop   = full_q && !granted;
            end else if (granted) begin
                full_d = 1'b0;
            end else if (aged) begin
                full_d = 1'b0;
                drop   = 1'b1;
            end
            cnt_d = cnt_q;
            if (drop && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end

        // Slot contents and saturating drop counter.
        always_ff @(posedge clk_96MHz or posedge reset) begin
            if (reset) begin
                full_q <= 1'b0;
                data_q <= '0;
                ts_q   <= '0;
                cnt_q  <= '0;
            end else begin
                full_q <= full_d;
                data_q <= data_d;
                ts_q   <= ts_d;
                cnt_q  <= cnt_d;
            end
        end

        assign slot_full[i]                           = full_q;
        assign slot_data[i]                           = data_q;
        assign slot_ts[i]                             = ts_q;
        assign drop_count[i*CNT_WIDTH +: CNT_WIDTH]   = cnt_q;
    end

    assign reset_bmc_decoder = rbmc_q;
    assign out_valid         = out_valid_q;
    assign out_channel       = out_channel_q;
    assign out_data          = out_data_q;
    assign out_timestamp     = out_ts_q;
    assign any_pending       = |slot_full;

endmodule

// File: tb/tb_receiver_channel_aggregator.sv
// tb/tb_receiver_channel_aggregator.sv - directed self-checking bench for receiver_channel_aggregator
module tb_receiver_channel_aggregator;

    localparam int N  = 4;
    localparam int DW = 17;
    localparam int TW = 24;
    localparam int CW = 2;

    logic            clk_96MHz = 1'b0;
    logic            reset;
    logic [N-1:0]    data_availible;
    logic [N*DW-1:0] decoded_data;
    logic [N*TW-1:0] timestamp_last_data;
    logic [TW-1:0]   system_timestamp;
    logic [N-1:0]    reset_bmc_decoder;
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      out_channel;
    logic [DW-1:0]   out_data;
    logic [TW-1:0]   out_timestamp;
    logic [N*CW-1:0] drop_count;
    logic            any_pending;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_96MHz = ~clk_96MHz;

    receiver_channel_aggregator #(
        .N_CHANNELS (N),
        .DATA_WIDTH (DW),
        .TS_WIDTH   (TW),
        .MAX_AGE    (100),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk_96MHz           (clk_96MHz),
        .reset               (reset),
        .data_availible      (data_availible),
        .decoded_data        (decoded_data),
        .timestamp_last_data (timestamp_last_data),
        .system_timestamp    (system_timestamp),
        .reset_bmc_decoder   (reset_bmc_decoder),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_channel         (out_channel),
        .out_data            (out_data),
        .out_timestamp       (out_timestamp),
        .drop_count          (drop_count),
        .any_pending         (any_pending)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_96MHz);
            #1;
        end
    endtask

    task automatic set_ch(input int ch, input logic [DW-1:0] d, input logic [TW-1:0] ts);
        decoded_data[ch*DW +: DW]        = d;
        timestamp_last_data[ch*TW +: TW] = ts;
    endtask

    task automatic check_out(input string tag, input logic [1:0] ch, input logic [DW-1:0] d);
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_chan"}, out_channel, ch);
        check({tag, "_data"}, out_data, d);
    endtask

    initial begin
        reset               = 1'b1;
        data_availible      = '0;
        decoded_data        = '0;
        timestamp_last_data = {N{24'h000100}};
        system_timestamp    = 24'h000100;
        out_ready           = 1'b0;
        step(2);
        check("rst_valid", out_valid, 1'b0);
        check("rst_rbmc", reset_bmc_decoder, 4'h0);
        check("rst_chan", out_channel, 2'd0);
        check("rst_data", out_data, 17'h0);
        check("rst_ts", out_timestamp, 24'h0);
        check("rst_drops", drop_count, 8'h00);
        check("rst_pending", any_pending, 1'b0);
        reset = 1'b0;
        step(2);

        // Fairness: all four rise together, served 0..3 back to back
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) set_ch(i, DW'(i + 1), 24'h000100);
        data_availible = 4'hF;
        step();
        check("fair_rbmc", reset_bmc_decoder, 4'hF);
        check("fair_pending", any_pending, 1'b1);
        check("fair_early_valid", out_valid, 1'b0);
        data_availible = 4'h0;
        for (int i = 0; i < N; i++) begin
            step();
            check_out($sformatf("fair%0d", i), 2'(i), DW'(i + 1));
        end
        step();
        check("fair_drain_valid", out_valid, 1'b0);
        check("fair_drain_pending", any_pending, 1'b0);
        check("fair_rbmc_done", reset_bmc_decoder, 4'h0);

        // Second round: channels 0 and 3 only
        set_ch(0, 17'h5, 24'h000100);
        set_ch(3, 17'h6, 24'h000100);
        data_availible = 4'b1001;
        step();
        check("rr_rbmc", reset_bmc_decoder, 4'b1001);
        data_availible = 4'h0;
        step();
        check_out("rr_first", 2'd0, 17'h5);
        step();
        check_out("rr_second", 2'd3, 17'h6);
        step();
        check("rr_drain_valid", out_valid, 1'b0);

        // Single capture on channel 2, two-cycle latency
        set_ch(2, 17'h1ABCD, 24'h000100);
        data_availible = 4'b0100;
        step();
        check("single_rbmc", reset_bmc_decoder, 4'b0100);
        check("single_early_valid", out_valid, 1'b0);
        check("single_pending", any_pending, 1'b1);
        data_availible = 4'h0;
        step();
        check_out("single", 2'd2, 17'h1ABCD);
        check("single_ts", out_timestamp, 24'h000100);
        check("single_rbmc_off", reset_bmc_decoder, 4'h0);
        step();
        check("single_drain_valid", out_valid, 1'b0);

        // Backpressure: output holds ch0 while ch1 is overwritten
        out_ready = 1'b0;
        set_ch(0, 17'h30, 24'h000100);
        data_availible = 4'b0001;
        step();
        data_availible = 4'h0;
        step();
        check_out("bp_hold0", 2'd0, 17'h30);
        set_ch(1, 17'h11, 24'h000100);
        data_availible = 4'b0010;
        step();
        check("bp_pending", any_pending, 1'b1);
        check("bp_no_drop_yet", drop_count[1*CW +: CW], 2'd0);
        data_availible = 4'h0;
        set_ch(1, 17'h22, 24'h000100);
        step();
        data_availible = 4'b0010;
        step();
        check("bp_drop1", drop_count[1*CW +: CW], 2'd1);
        check_out("bp_stable", 2'd0, 17'h30);
        data_availible = 4'h0;
        out_ready = 1'b1;
        step();
        check_out("bp_next", 2'd1, 17'h22);
        step();
        check("bp_drain_valid", out_valid, 1'b0);

        // Ageing across timestamp wrap, output occupied by ch2
        out_ready = 1'b0;
        set_ch(2, 17'h77, 24'h000100);
        data_availible = 4'b0100;
        step();
        data_availible = 4'h0;
        step();
        check_out("age_hold2", 2'd2, 17'h77);
        system_timestamp = 24'hFFFFF0;
        set_ch(3, 17'h99, 24'hFFFFF0);
        data_availible = 4'b1000;
        step();
        check("age_rbmc", reset_bmc_decoder, 4'b1000);
        check("age_pending0", any_pending, 1'b1);
        data_availible = 4'h0;
        system_timestamp = 24'h000050;
        step();
        check("age_held_50", any_pending, 1'b1);
        check("age_nodrop_50", drop_count[3*CW +: CW], 2'd0);
        system_timestamp = 24'h000054;
        step();
        check("age_held_54", any_pending, 1'b1);
        system_timestamp = 24'h000055;
        step();
        check("age_cleared_55", any_pending, 1'b0);
        check("age_drop3", drop_count[3*CW +: CW], 2'd1);
        check_out("age_out_stable", 2'd2, 17'h77);
        out_ready = 1'b1;
        step();
        check("age_drain_valid", out_valid, 1'b0);
        system_timestamp = 24'h000100;

        // Saturation: six rises on ch0 while output blocked (five overwrites)
        out_ready = 1'b0;
        set_ch(1, 17'h44, 24'h000100);
        data_availible = 4'b0010;
        step();
        data_availible = 4'h0;
        step();
        check_out("sat_hold1", 2'd1, 17'h44);
        set_ch(0, 17'h55, 24'h000100);
        for (int k = 0; k < 6; k++) begin
            data_availible = 4'b0001;
            step();
            data_availible = 4'h0;
            step();
        end
        check("sat_drop0", drop_count[0*CW +: CW], 2'd3);
        check("sat_all_drops", drop_count, 8'h47);
        check("sat_pending", any_pending, 1'b1);
        check_out("sat_out_stable", 2'd1, 17'h44);

        // Asynchronous reset in the middle of a pending transfer
        out_ready = 1'b1;
        #3;
        reset = 1'b1;
        data_availible = 4'b0101;
        #1;
        check("arst_valid", out_valid, 1'b0);
        check("arst_chan", out_channel, 2'd0);
        check("arst_data", out_data, 17'h0);
        check("arst_ts", out_timestamp, 24'h0);
        check("arst_drops", drop_count, 8'h00);
        check("arst_pending", any_pending, 1'b0);
        check("arst_rbmc", reset_bmc_decoder, 4'h0);
        step(2);
        check("arst_rbmc_held", reset_bmc_decoder, 4'h0);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("release_rbmc%0d", k), reset_bmc_decoder, 4'h0);
            check($sformatf("release_valid%0d", k), out_valid, 1'b0);
        end

        // Normal capture still works after release
        data_availible = 4'h0;
        step();
        set_ch(0, 17'h3, 24'h000100);
        data_availible = 4'b0001;
        step();
        check("post_rbmc", reset_bmc_decoder, 4'b0001);
        data_availible = 4'h0;
        step();
        check_out("post_out", 2'd0, 17'h3);
        check("post_drops", drop_count, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/receiver_channel_aggregator.md
Name: receiver_channel_aggregator

Overview:
- Parametrised N-channel collector between the per-photodiode single_receiver_manager instances and the pulse_identifier / serial_transmitter back end.
- Captures each channel's decoded word and its timestamp into a one-deep holding slot, then re-arms that channel's BMC decoder.
- Drops stale or overwritten samples and counts them.
- Presents slots one at a time, round-robin, on a valid/ready output stream.

Parameters:
- N_CHANNELS, 4, number of receiver channels (1..16)
- DATA_WIDTH, 17, decoded BMC word width
- TS_WIDTH, 24, system timestamp width (wraps at 2^TS_WIDTH)
- MAX_AGE, 960000, slot lifetime in clk_96MHz ticks (10 ms); 0 disables ageing
- CNT_WIDTH, 8, width of each saturating drop counter

Ports:
- clk_96MHz  input  1  system clock
- reset  input  1  asynchronous, active-high
- data_availible  input  N_CHANNELS  per-channel level from single_receiver_manager; stays high until that decoder is reset
- decoded_data  input  N_CHANNELS*DATA_WIDTH  channel i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- timestamp_last_data  input  N_CHANNELS*TS_WIDTH  channel i at bits [i*TS_WIDTH +: TS_WIDTH]
- system_timestamp  input  TS_WIDTH  free-running counter
- reset_bmc_decoder  output  N_CHANNELS  one-cycle re-arm pulse per channel
- out_valid  output  1  output word valid
- out_ready  input  1  downstream accepts
- out_channel  output  clog2(N_CHANNELS), min 1  source channel
- out_data  output  DATA_WIDTH  decoded word
- out_timestamp  output  TS_WIDTH  capture timestamp
- drop_count  output  N_CHANNELS*CNT_WIDTH  per-channel saturating drop counters
- any_pending  output  1  OR of all slot-full flags

Behaviour:
- Reset values:
  - all outputs 0, all slots empty, all counters 0
  - edge-detect registers 0
  - round-robin pointer = N_CHANNELS-1, so channel 0 is served first.
- Capture:
  - Registered rising-edge detect on data_availible[i]; edge seen in cycle t.
  - In cycle t+1: slot i is loaded with decoded_data and timestamp_last_data sampled at t; reset_bmc_decoder[i]=1 for that single cycle.
- Overwrite: an edge arrives while slot i is full and is not being granted in that cycle.
  - Slot takes the new data.
  - drop_count[i] increments.
- Ageing (MAX_AGE>0): each cycle, if slot i is full and (system_timestamp - slot_ts) mod 2^TS_WIDTH > MAX_AGE, then:
  - slot i is cleared;
  - drop_count[i] increments.
  - Wrap-around is handled by modular subtraction.
- Counters saturate at all-ones; no wrap. An overwrite and an age-drop on the same channel in the same cycle count once.
- Output register:
  - Loads when out_valid=0, or when out_valid&out_ready.
  - Source: first full slot found scanning from pointer+1 modulo N_CHANNELS.
  - On load: the granted slot is cleared, the pointer is set to the granted channel, and out_valid=1.
  - If no slot is full, out_valid goes 0 (after a handshake) or stays 0.
- Handshake rules:
  - out_data, out_channel and out_timestamp are stable while out_valid&!out_ready.
  - Back-to-back transfers at one per cycle are permitted.
- Simultaneous grant and capture on one channel:
  - The old contents go to the output.
  - The slot ends full with the new capture.
  - No drop is counted.
- Simultaneous grant and age-out on one channel: the grant wins; no drop is counted.
- Latency: rising edge at cycle t gives out_valid at cycle t+2 at the earliest.
- Reset asserted mid-transfer: everything clears immediately (asynchronous). No reset_bmc_decoder pulses are produced during or on release of reset.
- any_pending is combinational from the slot flags.

Decomposition:
- Shared package receiver_pkg holds:
  - DATA_WIDTH and TS_WIDTH defaults;
  - a channel-index width function (clog2 with minimum 1);
  - the MAX_AGE default constant.
- One sub-module, rr_arbiter: parametrised round-robin priority search; inputs request vector and pointer; outputs grant index and grant valid.
- Slot storage, ageing and counters stay inline in a generate loop.

Test Plan:
- Single capture. N=4; channel 2 rises with data 0x1ABCD, ts 0x000100, out_ready=1.
  - reset_bmc_decoder=4'b0100 for 1 cycle.
  - out_valid 2 cycles after the edge with channel=2, data=0x1ABCD, ts=0x000100.
- Fairness. All 4 channels rise in the same cycle with data 0x1,0x2,0x3,0x4; out_ready=1.
  - Outputs channel 0,1,2,3 on consecutive cycles.
  - Then two new edges on 0 and 3: order 0, then 3.
- Backpressure/overwrite. out_ready=0 and output holding channel 0; channel 1 rises twice with 0x11 then 0x22.
  - drop_count[1]=1.
  - After out_ready=1: channel 0, then channel 1 with data 0x22.
- Ageing across wrap. MAX_AGE=100, out_ready=0 while the output is occupied; slot 3 captured with ts 0xFFFFF0.
  - Slot 3 is still held at system_timestamp 0x000050.
  - Slot 3 is cleared, with drop_count[3]=1, once system_timestamp reaches 0x000055.
- Saturation and reset. CNT_WIDTH=2; force 5 overwrites on channel 0.
  - drop_count[0]=3.
  - Assert reset mid-transfer: all outputs 0 asynchronously; after release, no reset_bmc_decoder pulse.
